h75_pixel_writer: RTL and testbench
===================================

// Module: h75_pixel_writer
// PURPOSE
//  Upstream feeder for the HUB75 framebuffer write port (wr_en/wr_addr/wr_data).
//  Accepts a valid/ready RGB565 pixel stream with start-of-frame marker, tracks column/row,
//  produces linear framebuffer addresses (row*pixels_per_row + col) and registered write beats.
//  Re-syncs on SOF, flags framing/overflow errors, pulses frame_done per completed frame.
// PARAMETERS
//  NUM_ROWS    64     display rows per frame (both half-panels), 1..128
//  ADDR_W      15     framebuffer address width; depth = 2**ADDR_W
//  DATA_W      16     pixel word width
// PORTS
//  clk             in   1       single clock, all logic rising-edge
//  reset           in   1       synchronous, active-high
//  enable          in   1       1 = accept stream; 0 = drain to IDLE
//  pixels_per_row  in   10      pixels per row; sampled when leaving IDLE; valid 1..1023
//  pix_valid       in   1       stream beat valid
//  pix_ready       out  1       stream beat ready; transfer when valid&&ready
//  pix_sof         in   1       beat is first pixel of frame
//  pix_data        in   DATA_W  RGB565 pixel
//  wr_en           out  1       framebuffer write strobe, one beat per cycle max
//  wr_addr         out  ADDR_W  framebuffer address
//  wr_data         out  DATA_W  framebuffer data
//  frame_done      out  1       1-cycle pulse, last pixel of frame written
//  sof_err         out  1       1-cycle pulse, SOF received mid-frame
//  ovf_err         out  1       sticky until next SOF accepted: address overrun
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; pix_ready, wr_en, frame_done, sof_err, ovf_err, busy =0; wr_addr, wr_data =0;
//   col, row, row_base =0; ppr_q =0.
//  States: IDLE -> WAIT_SOF -> STREAM -> (last pixel) WAIT_SOF.
//   IDLE: pix_ready=0. If enable && pixels_per_row!=0: ppr_q<=pixels_per_row, ->WAIT_SOF.
//     enable with pixels_per_row==0: remain IDLE.
//   WAIT_SOF: pix_ready=1. Beats without SOF are consumed and discarded (no wr_en).
//     Beat with SOF: write at addr 0, col<=1 (or row advance if ppr_q==1), ->STREAM, clear ovf_err.
//   STREAM: pix_ready=1. Each beat written at row_base+col; col++;
//     at col==ppr_q-1: col<=0, row_base+=ppr_q, row++.
//     Last pixel (row==NUM_ROWS-1 && col==ppr_q-1): frame_done pulse with its wr_en, ->WAIT_SOF.
//  Address arithmetic: row_base+col computed ADDR_W+1 bits wide, no multiplier. Sum >= 2**ADDR_W:
//   beat discarded (no wr_en), ovf_err<=1, stay STREAM, keep counting to frame end (frame_done still pulses).
//  Latency: wr_en/wr_addr/wr_data registered, assert exactly 1 cycle after accepted beat;
//   wr_addr/wr_data hold last value when wr_en=0.
//  SOF in STREAM: sof_err pulse; beat treated as new-frame pixel 0 (written at addr 0); counters restart.
//  enable=0: IDLE entered next cycle from any state; pix_ready drops same cycle as registered state;
//   a beat accepted on the last ready cycle still produces its wr_en. Partial frame abandoned, no frame_done.
//  pixels_per_row changes outside IDLE ignored until next IDLE exit.
//  reset mid-frame: all outputs to reset values next cycle; in-flight beat dropped.
//  pix_ready never depends combinationally on pix_valid.
// TESTING
//  ppr=64, NUM_ROWS=64, 4096 beats SOF on first -> wr_addr 0..4095 in order, frame_done with addr 4095.
//  3 beats no SOF then SOF frame, ppr=4, NUM_ROWS=2 -> first 3 dropped, writes addr 0..7, frame_done once.
//  ppr=4, NUM_ROWS=2, SOF again at beat 5 -> sof_err pulse, that beat written addr 0, next at addr 1.
//  ppr=1023, NUM_ROWS=64 -> addr 32767 written, beats from 32768 dropped, ovf_err=1, frame_done at end.
//  pix_valid toggling 1/0 each cycle, ppr=8 -> wr_en exactly 1 cycle after each transfer, addresses contiguous.
//  enable drop mid-row at addr 10 -> IDLE, no frame_done; re-enable + SOF -> restart at addr 0.

Source files
------------

// File: rtl/h75_pixel_writer.sv
// h75_pixel_writer: turns a valid/ready RGB565 pixel stream with a start-of-frame
// marker into registered framebuffer write beats at linear addresses
// row*pixels_per_row + col. Re-syncs on SOF and reports framing/overflow errors.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// S_IDLE     | stream not accepted, pix_ready low, waits for enable
// S_WAIT_SOF | accepting beats, discarding all until a beat carries SOF
// S_STREAM   | writing pixels of the current frame

module h75_pixel_writer #(
    parameter int NUM_ROWS = 64,
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [9:0]        pixels_per_row,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              sof_err,
    output logic              ovf_err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SOF = 2'd1;
    localparam logic [1:0] S_STREAM   = 2'd2;

    // Sum width: one bit above the address so an overrun shows up as the MSB.
    localparam int SW    = ADDR_W + 1;
    localparam int ROW_W = 7;
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [SW:0]      ADDR_LIMIT = (SW + 1)'(1) << ADDR_W;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [9:0]       ppr_q;
    logic [9:0]       col;
    logic [9:0]       col_cur;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_cur;
    logic [SW-1:0]    row_base;
    logic [SW-1:0]    base_cur;
    logic [SW-1:0]    addr_sum;
    logic [SW:0]      base_adv;
    logic             fire;
    logic             restart;
    logic             take;
    logic             row_end;
    logic             frame_end;
    logic             in_range;
    logic             leave_idle;

    // Ready is a pure function of the registered state, never of pix_valid.
    assign pix_ready  = (state != S_IDLE);
    assign busy       = (state != S_IDLE);
    assign fire       = pix_ready && pix_valid;
    assign restart    = fire && pix_sof;
    assign take       = restart || (fire && (state == S_STREAM));
    assign leave_idle = (state == S_IDLE) && enable && (pixels_per_row != 10'd0);

    // An SOF beat always lands at the frame origin, whatever the counters hold.
    assign col_cur   = restart ? '0 : col;
    assign row_cur   = restart ? '0 : row;
    assign base_cur  = restart ? '0 : row_base;
    assign addr_sum  = base_cur + SW'(col_cur);
    assign in_range  = !addr_sum[SW-1];
    assign row_end   = (col_cur == (ppr_q - 10'd1));
    assign frame_end = row_end && (row_cur == LAST_ROW);
    // row_base saturates at the address limit so it can never wrap back into range.
    assign base_adv  = {1'b0, base_cur} + (SW + 1)'(ppr_q);

    // Next-state decode; enable low forces IDLE from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (leave_idle) begin
                    state_nxt = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF, S_STREAM: begin
                if (take) begin
                    state_nxt = frame_end ? S_WAIT_SOF : S_STREAM;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if ((state != S_IDLE) && !enable) begin
            state_nxt = S_IDLE;
        end
    end

    // State, position counters and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ppr_q      <= '0;
            col        <= '0;
            row        <= '0;
            row_base   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            if (leave_idle) begin
                ppr_q <= pixels_per_row;
            end
            if (take) begin
                if (in_range) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr_sum[ADDR_W-1:0];
                    wr_data <= pix_data;
                end
                frame_done <= frame_end;
                sof_err    <= restart && (state == S_STREAM);
                if (!in_range) begin
                    ovf_err <= 1'b1;
                end else if (restart) begin
                    ovf_err <= 1'b0;
                end
                if (frame_end) begin
                    col      <= '0;
                    row      <= '0;
                    row_base <= '0;
                end else if (row_end) begin
                    col      <= '0;
                    row      <= row_cur + ROW_W'(1);
                    row_base <= (base_adv >= ADDR_LIMIT) ? ADDR_LIMIT[SW-1:0]
                                                         : base_adv[SW-1:0];
                end else begin
                    col      <= col_cur + 10'd1;
                    row      <= row_cur;
                    row_base <= base_cur;
                end
            end
        end
    end

endmodule

// File: tb/tb_h75_pixel_writer.sv
// Bench for h75_pixel_writer: two instances (64-row and 2-row) share one stimulus
// stream; a frame-index reference model predicts every output every cycle, and a
// table of stream scenarios checks per-scenario write/frame totals.

module tb_h75_pixel_writer;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int OW = AW + DW + 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [9:0]    ppr;
    logic          valid;
    logic          sof;
    logic [DW-1:0] data;

    logic a_ready, a_wr_en, a_fd, a_se, a_ovf, a_busy;
    logic b_ready, b_wr_en, b_fd, b_se, b_ovf, b_busy;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;

    h75_pixel_writer #(.NUM_ROWS(64), .ADDR_W(AW), .DATA_W(DW)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .pixels_per_row(ppr),
        .pix_valid(valid), .pix_ready(a_ready), .pix_sof(sof), .pix_data(data),
        .wr_en(a_wr_en), .wr_addr(a_addr), .wr_data(a_data), .frame_done(a_fd),
        .sof_err(a_se), .ovf_err(a_ovf), .busy(a_busy));

    h75_pixel_writer #(.NUM_ROWS(2), .ADDR_W(AW), .DATA_W(DW)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .pixels_per_row(ppr),
        .pix_valid(valid), .pix_ready(b_ready), .pix_sof(sof), .pix_data(data),
        .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_data), .frame_done(b_fd),
        .sof_err(b_se), .ovf_err(b_ovf), .busy(b_busy));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // ---------------- reference model: frame position as one linear index ----
    int            nrows [2] = '{64, 2};
    int            m_mode[2];          // 0 idle, 1 hunting SOF, 2 in frame
    int            m_idx [2];
    int            m_ppr [2];
    logic          e_wr  [2];
    logic          e_fd  [2];
    logic          e_se  [2];
    logic          e_ovf [2];
    logic [AW-1:0] e_addr[2];
    logic [DW-1:0] e_data[2];

    task automatic model_step(input int i);
        int  old;
        bit  fire;
        if (reset) begin
            m_mode[i] = 0; m_idx[i] = 0; m_ppr[i] = 0;
            e_wr[i] = 0; e_fd[i] = 0; e_se[i] = 0; e_ovf[i] = 0;
            e_addr[i] = '0; e_data[i] = '0;
            return;
        end
        old  = m_mode[i];
        fire = (old != 0) && valid;
        e_wr[i] = 0; e_fd[i] = 0; e_se[i] = 0;
        if (old == 0) begin
            if (enable && ppr != 0) begin
                m_ppr[i]  = int'(ppr);
                m_mode[i] = 1;
            end
        end else begin
            if (fire && (sof || old == 2)) begin
                if (sof) begin
                    if (old == 2) e_se[i] = 1;
                    m_idx[i] = 0;
                    e_ovf[i] = 0;
                end
                if (m_idx[i] < (1 << AW)) begin
                    e_wr[i]   = 1;
                    e_addr[i] = AW'(m_idx[i]);
                    e_data[i] = data;
                end else begin
                    e_ovf[i] = 1;
                end
                if (m_idx[i] == nrows[i] * m_ppr[i] - 1) begin
                    e_fd[i]   = 1;
                    m_idx[i]  = 0;
                    m_mode[i] = 1;
                end else begin
                    m_idx[i]  = m_idx[i] + 1;
                    m_mode[i] = 2;
                end
            end
            if (!enable) m_mode[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    function automatic logic [OW-1:0] exp_vec(input int i);
        logic act;
        act = (m_mode[i] != 0);
        return {e_wr[i], e_addr[i], e_data[i], e_fd[i], e_se[i], e_ovf[i], act, act};
    endfunction

    // ---------------- per-cycle comparison and event counters ----------------
    int cnt_wr[2] = '{0, 0};
    int cnt_fd[2] = '{0, 0};
    int cnt_se[2] = '{0, 0};

    always @(negedge clk) begin
        logic [OW-1:0] oa, ob;
        oa = {a_wr_en, a_addr, a_data, a_fd, a_se, a_ovf, a_busy, a_ready};
        ob = {b_wr_en, b_addr, b_data, b_fd, b_se, b_ovf, b_busy, b_ready};
        if (chk_on) begin
            checks += 2;
            if (oa !== exp_vec(0)) begin
                errors++;
                $display("FAIL cycle_a t=%0t got %h expected %h", $time, oa, exp_vec(0));
            end
            if (ob !== exp_vec(1)) begin
                errors++;
                $display("FAIL cycle_b t=%0t got %h expected %h", $time, ob, exp_vec(1));
            end
        end
        if (a_wr_en) cnt_wr[0]++;
        if (b_wr_en) cnt_wr[1]++;
        if (a_fd)    cnt_fd[0]++;
        if (b_fd)    cnt_fd[1]++;
        if (a_se)    cnt_se[0]++;
        if (b_se)    cnt_se[1]++;
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    // ---------------- stimulus helpers (called at a falling edge) ------------
    task automatic do_reset();
        reset = 1'b1; valid = 1'b0; sof = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_beat(input bit s, input logic [DW-1:0] d);
        int  budget = 0;
        bit  ok;
        valid = 1'b1; sof = s; data = d;
        forever begin
            ok = a_ready;
            @(negedge clk);
            if (ok) break;
            budget++;
            if (budget > 50) begin
                errors++;
                $display("FAIL beat_timeout t=%0t got not_ready expected ready", $time);
                break;
            end
        end
        valid = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int ppr;
        int pre;
        int beats;
        int gap;      // 0 back-to-back, 1 one idle cycle, 2 random 0..2
        int a_wr, a_fd, a_last, a_ovf;
        int b_wr, b_fd, b_last, b_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int n, input vec_t v);
        int w0[2], f0[2];
        ppr = 10'(v.ppr);
        enable = 1'b1;
        do_reset();
        idle(2);
        for (int i = 0; i < 2; i++) begin w0[i] = cnt_wr[i]; f0[i] = cnt_fd[i]; end
        for (int k = 0; k < v.pre; k++) begin
            send_beat(1'b0, DW'($urandom));
            if (v.gap == 1) idle(1);
        end
        for (int k = 0; k < v.beats; k++) begin
            send_beat(k == 0, DW'($urandom));
            if (v.gap == 1) idle(1);
            else if (v.gap == 2) idle($urandom_range(0, 2));
        end
        idle(3);
        chk($sformatf("v%0d_a_writes", n), cnt_wr[0] - w0[0], v.a_wr);
        chk($sformatf("v%0d_a_frames", n), cnt_fd[0] - f0[0], v.a_fd);
        chk($sformatf("v%0d_a_last",   n), int'(a_addr), v.a_last);
        chk($sformatf("v%0d_a_ovf",    n), int'(a_ovf),  v.a_ovf);
        chk($sformatf("v%0d_b_writes", n), cnt_wr[1] - w0[1], v.b_wr);
        chk($sformatf("v%0d_b_frames", n), cnt_fd[1] - f0[1], v.b_fd);
        chk($sformatf("v%0d_b_last",   n), int'(b_addr), v.b_last);
        chk($sformatf("v%0d_b_ovf",    n), int'(b_ovf),  v.b_ovf);
    endtask

    initial begin
        int w0, f0, s0;
        vecs[0] = '{64,   0, 4096,  0, 4096,  1, 4095,  0,  128, 1,  127, 0};
        vecs[1] = '{4,    3, 8,     1, 8,     0, 7,     0,  8,   1,  7,   0};
        vecs[2] = '{8,    0, 40,    1, 40,    0, 39,    0,  16,  1,  15,  0};
        vecs[3] = '{1,    0, 70,    2, 64,    1, 63,    0,  2,   1,  1,   0};
        vecs[4] = '{1023, 0, 65472, 0, 32768, 1, 32767, 1,  2046, 1, 2045, 0};

        reset = 1'b1; enable = 1'b0; ppr = 10'd4; valid = 1'b0; sof = 1'b0; data = '0;
        @(negedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        chk("reset_busy_a", int'(a_busy), 0);
        chk("reset_addr_b", int'(b_addr), 0);
        reset = 1'b0;

        for (int n = 0; n < 5; n++) run_vec(n, vecs[n]);

        // SOF arriving mid-frame restarts at address 0
        ppr = 10'd4; enable = 1'b1;
        do_reset(); idle(2);
        s0 = cnt_se[1];
        for (int k = 0; k < 5; k++) send_beat(k == 0, DW'($urandom));
        send_beat(1'b1, 16'hA5A5);
        chk("sof_mid_addr", int'(b_addr), 0);
        send_beat(1'b0, 16'h1234);
        idle(2);
        chk("sof_err_count", cnt_se[1] - s0, 1);
        chk("sof_next_addr", int'(b_addr), 1);

        // enable drop mid-row; the beat on the last ready cycle is still written
        ppr = 10'd8;
        do_reset(); idle(2);
        w0 = cnt_wr[0]; f0 = cnt_fd[1];
        for (int k = 0; k < 11; k++) send_beat(k == 0, DW'($urandom));
        enable = 1'b0;
        send_beat(1'b0, 16'hBEEF);
        idle(3);
        chk("drop_busy", int'(a_busy), 0);
        chk("drop_writes", cnt_wr[0] - w0, 12);
        chk("drop_last_addr", int'(a_addr), 11);
        chk("drop_no_frame", cnt_fd[1] - f0, 0);
        enable = 1'b1; idle(2);
        send_beat(1'b1, 16'h0F0F);
        idle(2);
        chk("reenable_addr", int'(b_addr), 0);

        // reset with a beat in flight
        ppr = 10'd4;
        do_reset(); idle(2);
        for (int k = 0; k < 3; k++) send_beat(k == 0, DW'($urandom));
        valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        valid = 1'b0; reset = 1'b0;
        chk("rst_mid_wr", int'(a_wr_en), 0);
        chk("rst_mid_addr", int'(a_addr), 0);

        // zero pixels_per_row keeps the block idle
        ppr = 10'd0; idle(4);
        chk("ppr0_idle", int'(a_busy), 0);

        // random traffic, including ppr changes outside IDLE and enable drops
        ppr = 10'd3;
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 19) == 0) ppr = 10'($urandom_range(0, 6));
            valid = 1'($urandom);
            sof   = ($urandom_range(0, 15) == 0);
            data  = DW'($urandom);
            @(negedge clk);
        end
        valid = 1'b0; sof = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got running expected finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
